// File: rtl/cs_risc_pkg.sv
// Shared opcode constants, state encoding and decode helper for the RISC sequencer.
package cs_risc_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_ALU_R  = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ALU_I  = 6'b000001;
    localparam logic [OPC_W-1:0] OP_LOAD   = 6'b000010;
    localparam logic [OPC_W-1:0] OP_STORE  = 6'b000011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 6'b000100;
    localparam logic [OPC_W-1:0] OP_JUMP   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_HALT   = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUPD  = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    // Opcodes that run through the EXEC state.
    function automatic logic is_exec_op(input logic [OPC_W-1:0] op);
        return (op == OP_ALU_R) || (op == OP_ALU_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JUMP);
    endfunction

endpackage

// File: rtl/cs_risc_wait_timer.sv
// Consecutive wait-cycle counter; exists only when CS_RISC_SEQ_TIMEOUT_EN is defined.
`ifdef CS_RISC_SEQ_TIMEOUT_EN
module cs_risc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;

    assign stall     = wait_i && !ack_i;
    assign expired_o = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign cnt_d     = stall ? cnt_q + CW'(1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule
`endif

// File: rtl/cs_risc_seq_ctrl.sv
// Multi-cycle RISC control sequencer. Define CS_RISC_SEQ_TIMEOUT_EN to bound
// memory-ack waits with TIMEOUT_CYCLES (sticky err_o, then HALT).
module cs_risc_seq_ctrl
    import cs_risc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             branch_taken_i,
    input  logic             imem_ack_i,
    input  logic             dmem_ack_i,
    output logic             imem_req_o,
    output logic             ir_load_o,
    output logic             alu_en_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             rf_we_o,
    output logic             rf_wsel_o,
    output logic             pc_en_o,
    output logic             pc_sel_o,
    output logic             halted_o,
    output logic             illegal_o,
    output logic             err_o,
    output logic [2:0]       state_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e           state_q, state_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic             br_q, br_d;
    logic             tmo;

`ifdef CS_RISC_SEQ_TIMEOUT_EN
    logic err_q;

    cs_risc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .wait_i    ((state_q == S_FETCH) || (state_q == S_MEM)),
        .ack_i     ((state_q == S_FETCH) ? imem_ack_i : dmem_ack_i),
        .expired_o (tmo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   err_q <= 1'b0;
        else if (tmo) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Instruction context is always written before it is consumed, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        br_q <= br_d;
    end

    assign state_o = state_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        br_d       = br_q;
        imem_req_o = 1'b0;
        ir_load_o  = 1'b0;
        alu_en_o   = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        rf_we_o    = 1'b0;
        rf_wsel_o  = 1'b0;
        pc_en_o    = 1'b0;
        pc_sel_o   = 1'b0;
        halted_o   = 1'b0;
        illegal_o  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_load_o = 1'b1;
                    state_d   = S_DECODE;
                end else if (tmo) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                op_d = opcode_i;
                br_d = 1'b0;
                if (is_exec_op(opcode_i)) begin
                    state_d = S_EXEC;
                end else if (opcode_i == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = S_PCUPD;
                end
            end
            S_EXEC: begin
                alu_en_o = 1'b1;
                br_d     = (op_q == OP_JUMP) || ((op_q == OP_BRANCH) && branch_taken_i);
                if ((op_q == OP_LOAD) || (op_q == OP_STORE))       state_d = S_MEM;
                else if ((op_q == OP_BRANCH) || (op_q == OP_JUMP)) state_d = S_PCUPD;
                else                                               state_d = S_WB;
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (op_q == OP_STORE);
                if (dmem_ack_i)  state_d = (op_q == OP_LOAD) ? S_WB : S_PCUPD;
                else if (tmo)    state_d = S_HALT;
            end
            S_WB: begin
                rf_we_o   = 1'b1;
                rf_wsel_o = (op_q == OP_LOAD);
                state_d   = S_PCUPD;
            end
            S_PCUPD: begin
                pc_en_o  = 1'b1;
                pc_sel_o = br_q;
                state_d  = S_FETCH;
            end
            S_HALT:  halted_o = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cs_risc_seq_ctrl.sv
// Randomized bench for cs_risc_seq_ctrl against a per-instruction cycle-schedule model.
module tb_cs_risc_seq_ctrl;
    import cs_risc_pkg::*;

    localparam int TO = 4;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
    localparam int ST_MEM = 4, ST_WB = 5, ST_PCUPD = 6, ST_HALT = 7;

    localparam int O_IREQ = 11, O_IRLD = 10, O_ALU = 9, O_DREQ = 8, O_DWE = 7, O_RFWE = 6;
    localparam int O_WSEL = 5, O_PCEN = 4, O_PCSEL = 3, O_HALT = 2, O_ILL = 1, O_ERR = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode_i = '0;
    logic       branch_taken_i = 1'b0, imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
    logic       imem_req_o, ir_load_o, alu_en_o, dmem_req_o, dmem_we_o, rf_we_o;
    logic       rf_wsel_o, pc_en_o, pc_sel_o, halted_o, illegal_o, err_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    cs_risc_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i), .branch_taken_i(branch_taken_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .imem_req_o(imem_req_o),
        .ir_load_o(ir_load_o), .alu_en_o(alu_en_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .rf_we_o(rf_we_o), .rf_wsel_o(rf_wsel_o), .pc_en_o(pc_en_o),
        .pc_sel_o(pc_sel_o), .halted_o(halted_o), .illegal_o(illegal_o), .err_o(err_o),
        .state_o(state_o)
    );

    typedef struct {
        logic [2:0]  st;
        logic [11:0] outs;
        logic        ia, da, bt;
        logic [5:0]  op;
    } cyc_t;

    cyc_t q[$];
    bit   err_m, halt_m;
    int   n_chk, n_pass, cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [11:0] obs_vec();
        return {imem_req_o, ir_load_o, alu_en_o, dmem_req_o, dmem_we_o, rf_we_o,
                rf_wsel_o, pc_en_o, pc_sel_o, halted_o, illegal_o, err_o};
    endfunction

    function automatic logic [11:0] b(input int pos);
        return 12'(1) << pos;
    endfunction

    // ia/da/bt < 0 means "don't care": drive random noise that the DUT must ignore.
    task automatic push(input int st, input logic [11:0] outs, input int ia, input int da,
                        input int bt, input int op);
        cyc_t e;
        e.st   = 3'(st);
        e.outs = outs;
        e.outs[O_ERR] = err_m;
        e.ia = (ia < 0) ? 1'($urandom) : 1'(ia);
        e.da = (da < 0) ? 1'($urandom) : 1'(da);
        e.bt = (bt < 0) ? 1'($urandom) : 1'(bt);
        e.op = (op < 0) ? 6'($urandom) : 6'(op);
        q.push_back(e);
    endtask

    task automatic model_instr(input logic [5:0] op, input int bt, input int iw, input int dw);
        bit sel, is_mem, is_st;
        if (halt_m) return;
        for (int i = 0; i < iw; i++) begin
            push(ST_FETCH, b(O_IREQ), 0, -1, -1, -1);
`ifdef CS_RISC_SEQ_TIMEOUT_EN
            if (i == TO - 1) begin err_m = 1; halt_m = 1; return; end
`endif
        end
        push(ST_FETCH, b(O_IREQ) | b(O_IRLD), 1, -1, -1, -1);
        if (op == OP_HALT) begin
            push(ST_DECODE, '0, -1, -1, -1, op);
            halt_m = 1;
            return;
        end
        if (!(op inside {OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP})) begin
            push(ST_DECODE, b(O_ILL), -1, -1, -1, op);
            push(ST_PCUPD, b(O_PCEN), -1, -1, -1, op);
            return;
        end
        push(ST_DECODE, '0, -1, -1, -1, op);
        push(ST_EXEC, b(O_ALU), -1, -1, bt, op);
        sel    = (op == OP_JUMP) || ((op == OP_BRANCH) && bt != 0);
        is_st  = (op == OP_STORE);
        is_mem = (op == OP_LOAD) || is_st;
        if (is_mem) begin
            for (int i = 0; i < dw; i++) begin
                push(ST_MEM, b(O_DREQ) | (is_st ? b(O_DWE) : '0), -1, 0, -1, op);
`ifdef CS_RISC_SEQ_TIMEOUT_EN
                if (i == TO - 1) begin err_m = 1; halt_m = 1; return; end
`endif
            end
            push(ST_MEM, b(O_DREQ) | (is_st ? b(O_DWE) : '0), -1, 1, -1, op);
            if (op == OP_LOAD) push(ST_WB, b(O_RFWE) | b(O_WSEL), -1, -1, -1, op);
        end else if (op == OP_ALU_R || op == OP_ALU_I) begin
            push(ST_WB, b(O_RFWE), -1, -1, -1, op);
        end
        push(ST_PCUPD, b(O_PCEN) | (sel ? b(O_PCSEL) : '0), -1, -1, -1, op);
    endtask

    task automatic run_n(input int n);
        cyc_t e;
        repeat (n) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                @(posedge clk);
                #1;
                opcode_i = e.op; imem_ack_i = e.ia; dmem_ack_i = e.da; branch_taken_i = e.bt;
                #1;
                cyc++;
                chk($sformatf("state@%0d", cyc), 32'(state_o), 32'(e.st));
                chk($sformatf("outs@%0d", cyc), 32'(obs_vec()), 32'(e.outs));
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(state_o), ST_IDLE);
        chk({tag, "_outs"}, 32'(obs_vec()), 0);
    endtask

    initial begin
        int r;
        #2 reset = 1'b0;
        #1 check_idle("rst_async");
        repeat (2) @(posedge clk);
        #1 check_idle("rst_hold");
        @(negedge clk) reset = 1'b1;
        #1 check_idle("idle_after_rel");

        model_instr(OP_ALU_R, 0, 0, 0);
        model_instr(OP_LOAD, 0, 0, 3);
        model_instr(OP_BRANCH, 1, 0, 0);
        model_instr(OP_BRANCH, 0, 0, 0);
        model_instr(6'b001111, 0, 0, 0);
        model_instr(OP_JUMP, 0, 1, 0);
        model_instr(OP_STORE, 0, 2, 1);
        run_n(q.size());

        // STORE waiting on dmem_ack: pull reset in the middle of the second MEM cycle.
        model_instr(OP_STORE, 0, 0, 5);
        run_n(5);
        #1 reset = 1'b0;
        #1;
        chk("rst_mem_dreq", 32'(dmem_req_o), 0);
        chk("rst_mem_dwe", 32'(dmem_we_o), 0);
        check_idle("rst_mem");
        q.delete();
        err_m = 0;
        halt_m = 0;
        repeat (2) @(posedge clk);
        #1 check_idle("rst_mem_hold");
        @(negedge clk) reset = 1'b1;
        #1 check_idle("rst_mem_rel");

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: model_instr(OP_ALU_R, 0, $urandom_range(0, 2), 0);
                1: model_instr(OP_ALU_I, 0, $urandom_range(0, 2), 0);
                2: model_instr(OP_LOAD, 0, $urandom_range(0, 2), $urandom_range(0, 2));
                3: model_instr(OP_STORE, 0, $urandom_range(0, 2), $urandom_range(0, 2));
                4: model_instr(OP_BRANCH, $urandom_range(0, 1), $urandom_range(0, 2), 0);
                5, 7: model_instr(OP_JUMP, $urandom_range(0, 1), $urandom_range(0, 2), 0);
                default: model_instr(6'($urandom_range(6, 62)), 0, $urandom_range(0, 2), 0);
            endcase
        end
        run_n(q.size());

        model_instr(OP_ALU_I, 0, TO + 2, 0);
        model_instr(OP_HALT, 0, 0, 0);
        for (int k = 0; k < 20; k++) push(ST_HALT, b(O_HALT), -1, -1, -1, -1);
        run_n(q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cs_risc_seq_ctrl.md
CS_RISC_SEQ_CTRL -- requirements
Module: cs_risc_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: memory-ack wait limit in cycles; used only with CS_RISC_SEQ_TIMEOUT_EN.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset; asserted at 0.
REQ-004 SHALL have port opcode_i  in  6  opcode field of the instruction register.
REQ-005 SHALL have port branch_taken_i  in  1  ALU branch condition; valid in EXEC.
REQ-006 SHALL have port imem_ack_i  in  1  instruction memory done.
REQ-007 SHALL have port dmem_ack_i  in  1  data memory done.
REQ-008 SHALL have outputs imem_req_o, ir_load_o, alu_en_o, dmem_req_o, dmem_we_o, rf_we_o, rf_wsel_o (0 = ALU, 1 = memory), pc_en_o, pc_sel_o (0 = PC+4, 1 = target), halted_o, illegal_o, err_o, each 1 bit.
REQ-009 SHALL have port state_o  out  3  current state code, for debug.

Function
REQ-010 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT.
REQ-011 IDLE: SHALL go to FETCH on the first clk edge after reset is released.
REQ-012 FETCH: imem_req_o=1 every FETCH cycle; on a cycle with imem_ack_i=1, SHALL assert ir_load_o=1 in that cycle and go to DECODE next; otherwise stay in FETCH.
REQ-013 DECODE: 1 cycle. SHALL go to EXEC for ALU_R, ALU_I, LOAD, STORE, BRANCH and JUMP; SHALL go to HALT for HALT.
REQ-014 DECODE, any other opcode: SHALL pulse illegal_o for 1 cycle and go to PCUPD with pc_sel_o=0, so the opcode acts as a NOP.
REQ-015 EXEC: alu_en_o=1 for 1 cycle. Next state: ALU_R/ALU_I -> WB; LOAD/STORE -> MEM; BRANCH/JUMP -> PCUPD.
REQ-016 EXEC: SHALL register branch_taken_i for BRANCH and force the registered value to 1 for JUMP.
REQ-017 MEM: dmem_req_o=1, and dmem_we_o=1 for STORE only. On dmem_ack_i=1: LOAD -> WB, STORE -> PCUPD; otherwise stay in MEM.
REQ-018 WB: rf_we_o=1 for 1 cycle; rf_wsel_o=1 for LOAD, else 0. Next state: PCUPD.
REQ-019 PCUPD: pc_en_o=1 for 1 cycle with pc_sel_o = registered branch flag (0 for non-branch opcodes). Next state: FETCH.
REQ-020 Cycle counts with zero-wait ack: ALU 5, LOAD 6, STORE 5, BRANCH/JUMP 4; each wait cycle adds 1.
REQ-021 HALT: halted_o=1 and all other strobes 0; SHALL stay in HALT until reset.
REQ-022 rf_we_o, pc_en_o and dmem_req_o SHALL never be asserted in the same cycle; at most one strobe per state.
REQ-023 An ack arriving outside its own request state SHALL be ignored.

Reset
REQ-024 While reset=0, state SHALL be IDLE and all outputs 0, taking effect immediately without waiting for clk.
REQ-025 Reset asserted mid-FETCH or mid-MEM SHALL drop the request in the same cycle and SHALL write nothing to the register file or PC.

Configuration
REQ-026 With CS_RISC_SEQ_TIMEOUT_EN defined: count consecutive wait cycles in FETCH or MEM. Reaching TIMEOUT_CYCLES without ack SHALL set err_o (sticky until reset) and enter HALT. The counter clears on state exit.
REQ-027 Without CS_RISC_SEQ_TIMEOUT_EN: waits are unbounded, err_o is tied to 0, and no counter logic exists.

Structure
REQ-028 Package cs_risc_pkg SHALL hold the opcode constants (ALU_R=000000, ALU_I=000001, LOAD=000010, STORE=000011, BRANCH=000100, JUMP=000101, HALT=111111), the state encoding (IDLE=0 .. HALT=7) and the opcode width.
REQ-029 The timeout counter SHALL be the sub-module cs_risc_wait_timer, instantiated only under the macro.

Verification
REQ-030 Release reset, ALU_R, acks tied 1 -> FETCH,DECODE,EXEC,WB,PCUPD; rf_we_o at cycle 4, pc_en_o at cycle 5 with pc_sel_o=0.
REQ-031 LOAD, dmem_ack_i delayed 3 cycles -> dmem_req_o high for 4 cycles, then rf_we_o=1 with rf_wsel_o=1; 9 cycles total.
REQ-032 BRANCH with branch_taken_i=1, then BRANCH with 0 -> pc_sel_o is 1 then 0 at the respective pc_en_o pulses.
REQ-033 Opcode 001111 -> illegal_o pulses 1 cycle, no rf_we_o, pc_en_o with pc_sel_o=0. Then HALT -> halted_o=1 stays, with imem_req_o=0 for 20 cycles.
REQ-034 Reset to 0 mid-MEM of a STORE -> dmem_req_o/dmem_we_o fall before the next clk edge; state_o=0.
REQ-035 Macro defined, TIMEOUT_CYCLES=4, imem_ack_i held 0 -> err_o=1 and halted_o=1 after 4 FETCH cycles. Macro undefined -> FETCH held, err_o=0.
